pll_mode_sequencer: RTL and testbench

Sequences a runtime retune of the core's fractional video/system PLL through the PLL reconfiguration controller's Avalon-MM management port. On a request it loads one of four preset frequency configurations (N, M, C0 and fractional K counter words), starts the reconfiguration, and supervises loss and reacquisition of lock. It sits between the core's mode/region logic and the `pll_cfg` reconfiguration IP, and is that port's only master.

---
 rtl/pll_mode_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_mode_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_mode_sequencer.sv
// Retunes the fractional PLL through its reconfiguration port: loads one of four
// presets, starts the reconfiguration and supervises loss and reacquisition of lock.
module pll_mode_sequencer #(
  parameter logic [127:0] MODE0_CFG = {32'h00010000, 32'h00000404, 32'h00000505, 32'h9745BF27},
  parameter logic [127:0] MODE1_CFG = MODE0_CFG,
  parameter logic [127:0] MODE2_CFG = MODE0_CFG,
  parameter logic [127:0] MODE3_CFG = MODE0_CFG,
  parameter int unsigned  LOCK_TIMEOUT = 2000000,
  parameter int unsigned  TW = 21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [1:0]  mode_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  cur_mode
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_K, S_WR_START,
    S_WAIT_UNLOCK, S_WAIT_LOCK, S_FINISH
  } state_t;

  localparam logic [TW-1:0] LP_TMO = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] LP_SAT = TW'(LOCK_TIMEOUT);

  state_t         r_state;
  state_t         w_nxt;
  logic           r_gap;
  logic [TW-1:0]  r_cnt;
  logic [1:0]     r_mode;
  logic           r_pend;
  logic [1:0]     r_pend_mode;
  logic           r_err;
  logic [1:0]     r_cur_mode;

  logic [127:0]   w_cfg;
  logic [5:0]     w_addr;
  logic [31:0]    w_data;
  logic           w_is_wr;
  logic           w_wr_done;
  logic           w_tmo;
  logic           w_accept;

  always_comb begin
    w_cfg = MODE0_CFG;
    case (r_mode)
      2'd1:    w_cfg = MODE1_CFG;
      2'd2:    w_cfg = MODE2_CFG;
      2'd3:    w_cfg = MODE3_CFG;
      default: w_cfg = MODE0_CFG;
    endcase
  end

  always_comb begin
    w_addr  = 6'h00;
    w_data  = 32'h0;
    w_is_wr = 1'b1;
    case (r_state)
      S_WR_MODE:  begin w_addr = 6'h00; w_data = 32'h0; end
      S_WR_N:     begin w_addr = 6'h03; w_data = w_cfg[127:96]; end
      S_WR_M:     begin w_addr = 6'h04; w_data = w_cfg[95:64]; end
      // bits [22:18] select the output counter; C0 is counter 0
      S_WR_C0:    begin w_addr = 6'h05; w_data = w_cfg[63:32] & ~32'h007C0000; end
      S_WR_K:     begin w_addr = 6'h07; w_data = w_cfg[31:0]; end
      S_WR_START: begin w_addr = 6'h02; w_data = 32'h1; end
      default:    w_is_wr = 1'b0;
    endcase
  end

  assign w_wr_done = mgmt_write & ~mgmt_waitrequest;
  assign w_tmo     = (r_cnt >= LP_TMO);
  assign w_accept  = (r_state == S_IDLE) & (req | r_pend);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:        if (req || r_pend) w_nxt = S_WR_MODE;
      S_WR_MODE:     if (r_gap) w_nxt = S_WR_N;
      S_WR_N:        if (r_gap) w_nxt = S_WR_M;
      S_WR_M:        if (r_gap) w_nxt = S_WR_C0;
      S_WR_C0:       if (r_gap) w_nxt = S_WR_K;
      S_WR_K:        if (r_gap) w_nxt = S_WR_START;
      S_WR_START:    if (w_wr_done) w_nxt = S_WAIT_UNLOCK;
      // an unchanged lock after a retune is legal, so a timeout here is not an error
      S_WAIT_UNLOCK: if (!pll_locked || w_tmo) w_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (pll_locked)  w_nxt = S_FINISH;
        else if (w_tmo)  w_nxt = S_IDLE;
      end
      S_FINISH:      w_nxt = S_IDLE;
      default:       w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_gap       <= 1'b0;
      r_cnt       <= '0;
      r_mode      <= 2'd0;
      r_pend      <= 1'b0;
      r_pend_mode <= 2'd0;
      r_err       <= 1'b0;
      r_cur_mode  <= 2'd0;
    end else begin
      r_state <= w_nxt;

      if (r_gap)
        r_gap <= 1'b0;
      else if (w_wr_done && r_state != S_WR_START)
        r_gap <= 1'b1;

      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_cnt != LP_SAT)
        r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_mode <= req ? mode_sel : r_pend_mode;
        r_pend <= 1'b0;
        r_err  <= 1'b0;
      end else if (req) begin
        r_pend      <= 1'b1;
        r_pend_mode <= mode_sel;
      end

      if (r_state == S_WAIT_LOCK && !pll_locked && w_tmo)
        r_err <= 1'b1;

      if (r_state == S_FINISH)
        r_cur_mode <= r_mode;
    end
  end

  assign mgmt_write     = w_is_wr & ~r_gap;
  assign mgmt_address   = w_addr;
  assign mgmt_writedata = w_data;
  assign busy           = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done           = (r_state == S_FINISH);
  assign err            = r_err;
  assign cur_mode       = r_cur_mode;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Scoreboard bench for pll_mode_sequencer: expected writes and done events are
// queued by the stimulus and consumed by an independent monitor.
module tb_pll_mode_sequencer;

  localparam logic [127:0] M0 = {32'h00010000, 32'h00000404, 32'h00000505, 32'h9745BF27};
  localparam logic [127:0] M1 = {32'h00000001, 32'h00000011, 32'h00FC0012, 32'h00001111};
  localparam logic [127:0] M2 = {32'h00000002, 32'h00000022, 32'h00000022, 32'h00002222};
  localparam logic [127:0] M3 = {32'h00000003, 32'h00000033, 32'h00000033, 32'h00003333};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        pll_locked = 1'b1;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        busy, done, err;
  logic [1:0]  cur_mode;

  pll_mode_sequencer #(
    .MODE0_CFG(M0), .MODE1_CFG(M1), .MODE2_CFG(M2), .MODE3_CFG(M3),
    .LOCK_TIMEOUT(100), .TW(21)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mode_sel(mode_sel),
    .pll_locked(pll_locked), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
    .busy(busy), .done(done), .err(err), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [37:0] exp_q[$];
  logic [1:0]  done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Hand-written register image per preset; mode 1 C0 has bits [22:18] cleared.
  task automatic push_seq(input int m, input int n);
    logic [5:0]  a[6];
    logic [31:0] d[6];
    a[0] = 6'h00; a[1] = 6'h03; a[2] = 6'h04; a[3] = 6'h05; a[4] = 6'h07; a[5] = 6'h02;
    d[0] = 32'h0; d[5] = 32'h1;
    case (m)
      0: begin d[1] = 32'h00010000; d[2] = 32'h00000404; d[3] = 32'h00000505; d[4] = 32'h9745BF27; end
      1: begin d[1] = 32'h00000001; d[2] = 32'h00000011; d[3] = 32'h00800012; d[4] = 32'h00001111; end
      2: begin d[1] = 32'h00000002; d[2] = 32'h00000022; d[3] = 32'h00000022; d[4] = 32'h00002222; end
      default: begin d[1] = 32'h00000003; d[2] = 32'h00000033; d[3] = 32'h00000033; d[4] = 32'h00003333; end
    endcase
    for (int i = 0; i < n; i++) exp_q.push_back({a[i], d[i]});
  endtask

  task automatic issue_req(input logic [1:0] m);
    @(posedge clk); #1;
    req = 1'b1;
    mode_sel = m;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // which: 0 = START write completes, 1 = done, 2 = err
  task automatic wait_for(input int which, input int budget, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 1; i <= budget && !hit; i++) begin
      @(negedge clk);
      cyc = i;
      case (which)
        0: hit = mgmt_write && !mgmt_waitrequest && mgmt_address == 6'h02;
        1: hit = done;
        default: hit = err;
      endcase
    end
    if (!hit) fail_now($sformatf("wait_for(%0d) timed out", which));
  endtask

  task automatic lock_blip(input int n);
    @(posedge clk); #1;
    pll_locked = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    @(negedge clk);
    check("done before lock seen", done, 0);
    @(negedge clk);
    check("done after relock", done, 1);
  endtask

  // Monitor: write scoreboard, strobe hold, inter-write gap, done events.
  logic        hold_vld = 1'b0, gap_chk = 1'b0, mode_chk_vld = 1'b0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;
  logic [1:0]  mode_chk;
  logic [37:0] e_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_vld = 1'b0;
      gap_chk = 1'b0;
      mode_chk_vld = 1'b0;
    end else begin
      if (mode_chk_vld) begin
        check("cur_mode after done", cur_mode, mode_chk);
        mode_chk_vld = 1'b0;
      end
      if (gap_chk) begin
        check("write gap", mgmt_write, 0);
        gap_chk = 1'b0;
      end
      if (hold_vld) begin
        check("held strobe", mgmt_write, 1);
        check("held addr/data", {mgmt_address, mgmt_writedata}, {hold_a, hold_d});
      end
      hold_vld = 1'b0;
      if (mgmt_write && mgmt_waitrequest) begin
        hold_vld = 1'b1;
        hold_a = mgmt_address;
        hold_d = mgmt_writedata;
      end
      if (mgmt_write && !mgmt_waitrequest) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected write addr %0h data %0h", mgmt_address, mgmt_writedata));
        end else begin
          e_w = exp_q.pop_front();
          check("write addr/data", {mgmt_address, mgmt_writedata}, e_w);
          gap_chk = 1'b1;
        end
      end
      if (done) begin
        check("busy at done", busy, 0);
        if (done_q.size() == 0) begin
          fail_now("unexpected done");
        end else begin
          mode_chk = done_q.pop_front();
          mode_chk_vld = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy/done/err", {busy, done, err}, 3'b000);
    check("reset cur_mode", cur_mode, 0);
    check("reset mgmt bus", {mgmt_write, mgmt_address, mgmt_writedata}, 39'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Mode 0, no waitrequest, fixed write timing
    push_seq(0, 6);
    done_q.push_back(2'd0);
    issue_req(2'd0);
    @(negedge clk);
    check("cycle1 busy/write", {busy, mgmt_write}, 2'b11);
    repeat (10) @(negedge clk);
    check("cycle11 START strobe", {mgmt_write, mgmt_address}, {1'b1, 6'h02});
    lock_blip(50);
    @(negedge clk);
    check("mode0 busy/err", {busy, err}, 2'b00);

    // Mode 1 with waitrequest on WR_M, then pending requests 2 and 3
    push_seq(1, 6);
    push_seq(3, 6);
    done_q.push_back(2'd1);
    done_q.push_back(2'd3);
    issue_req(2'd1);
    repeat (4) @(posedge clk);
    #1;
    mgmt_waitrequest = 1'b1;
    check("WR_M held addr", mgmt_address, 6'h04);
    repeat (7) @(posedge clk);
    #1;
    mgmt_waitrequest = 1'b0;
    issue_req(2'd2);
    issue_req(2'd3);
    wait_for(0, 100, cyc);
    lock_blip(20);
    wait_for(0, 100, cyc);
    lock_blip(10);
    @(negedge clk);
    check("after pending busy", busy, 0);

    // Reset in the middle of WR_K
    push_seq(1, 4);
    issue_req(2'd1);
    repeat (8) @(posedge clk);
    #1;
    check("WR_K strobe", {mgmt_write, mgmt_address}, {1'b1, 6'h07});
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset write/busy", {mgmt_write, busy}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("cur_mode after reset", cur_mode, 0);
    push_seq(2, 6);
    done_q.push_back(2'd2);
    issue_req(2'd2);
    wait_for(0, 100, cyc);
    lock_blip(5);

    // Lock never returns: err after the WAIT_LOCK window, cur_mode unchanged
    @(posedge clk); #1;
    pll_locked = 1'b0;
    push_seq(1, 6);
    issue_req(2'd1);
    wait_for(0, 100, cyc);
    wait_for(2, 300, cyc);
    check("err latency", cyc, 102);
    check("timeout busy/err", {busy, err}, 2'b01);
    check("timeout cur_mode", cur_mode, 2);

    // Lock stays high: WAIT_UNLOCK times out, then done without err
    pll_locked = 1'b1;
    push_seq(0, 6);
    done_q.push_back(2'd0);
    issue_req(2'd0);
    @(negedge clk);
    check("err cleared by req", err, 0);
    wait_for(0, 100, cyc);
    wait_for(1, 300, cyc);
    check("no-unlock done latency", cyc, 102);
    check("no-unlock err", err, 0);
    repeat (3) @(negedge clk);
    check("final cur_mode", cur_mode, 0);
    check("writes left", exp_q.size(), 0);
    check("dones left", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
